shot_event_detect: RTL and testbench

- Downstream of the dual-axis flick filter, in the 4 MHz SPI/filter clock domain.
- Pairs each X/Y flick sample and tracks a shot from trigger to release.
- On release, reports one shot event: per-axis peak, combined peak magnitude and shot length.
- Applies a lockout afterwards so that one physical flick produces exactly one event, for the game/scoring logic and the display freeze.

---
 rtl/shot_pkg.sv | 49 ++++
 rtl/xy_pair_sync.sv | 61 ++++++
 rtl/shot_event_detect.sv | 174 +++++++++++++++++
 tb/tb_shot_event_detect.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shot_pkg
//  Description : Shared definitions for the shot event detector: data widths,
//                FSM state encoding, default thresholds (also consumed by the
//                game-logic block), the result record and small helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package shot_pkg;

    localparam int FLICK_W = 16;
    localparam int MAG_W   = 17;
    localparam int LEN_W   = 8;
    localparam int CD_W    = 16;

    // FSM state encoding
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] TRACK    = 2'd1;
    localparam logic [1:0] REPORT   = 2'd2;
    localparam logic [1:0] COOLDOWN = 2'd3;

    // Default thresholds, shared with the game/scoring logic
    localparam logic [MAG_W-1:0] TRIG_TH_DEF          = 17'd200;
    localparam logic [MAG_W-1:0] REL_TH_DEF           = 17'd100;
    localparam int               MIN_SAMPLES_DEF      = 3;
    localparam int               MAX_SAMPLES_DEF      = 64;
    localparam int               COOLDOWN_SAMPLES_DEF = 8;

    typedef struct packed {
        logic [FLICK_W-1:0] x_peak;
        logic [FLICK_W-1:0] y_peak;
        logic [MAG_W-1:0]   mag;
        logic [LEN_W-1:0]   len;
    } shot_result_t;

    // Unsigned max; on a tie the stored value (cur) is kept.
    function automatic logic [FLICK_W-1:0] max_flick(input logic [FLICK_W-1:0] cur,
                                                     input logic [FLICK_W-1:0] smp);
        return (smp > cur) ? smp : cur;
    endfunction

    // Combined magnitude; one extra bit makes overflow impossible.
    function automatic logic [MAG_W-1:0] mag_sum(input logic [FLICK_W-1:0] x,
                                                 input logic [FLICK_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/xy_pair_sync.sv
`default_nettype none
// ============================================================================
//  Module      : xy_pair_sync
//  Description : Latches the X flick sample and pairs it with the next Y
//                sample, producing a one-cycle pair_stb the cycle after the
//                pairing Y strobe.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                x_valid, x_flick - X sample strobe and value
//                y_valid, y_flick - Y sample strobe and value
//                pair_stb         - one-cycle strobe, pair_x/pair_y valid
//                pair_x, pair_y   - latched sample pair
//  Revision    : 1.0  initial release
// ============================================================================
module xy_pair_sync
    import shot_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               x_valid,
    input  logic [FLICK_W-1:0] x_flick,
    input  logic               y_valid,
    input  logic [FLICK_W-1:0] y_flick,
    output logic               pair_stb,
    output logic [FLICK_W-1:0] pair_x,
    output logic [FLICK_W-1:0] pair_y
);

    logic [FLICK_W-1:0] r_x_lat;
    logic [FLICK_W-1:0] r_y_lat;
    logic               r_x_have;
    logic               r_pair_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_lat    <= '0;
            r_y_lat    <= '0;
            r_x_have   <= 1'b0;
            r_pair_stb <= 1'b0;
        end else begin
            r_pair_stb <= 1'b0;
            // A repeated X before its Y simply overwrites the latch.
            if (x_valid) begin
                r_x_lat <= x_flick;
            end
            if (y_valid && (x_valid || r_x_have)) begin
                r_y_lat    <= y_flick;
                r_pair_stb <= 1'b1;
                r_x_have   <= 1'b0;
            end else if (x_valid) begin
                r_x_have <= 1'b1;
            end
            // A Y with no pending X falls through and is dropped.
        end
    end

    assign pair_stb = r_pair_stb;
    assign pair_x   = r_x_lat;
    assign pair_y   = r_y_lat;

endmodule
`default_nettype wire

// File: rtl/shot_event_detect.sv
`default_nettype none
// ============================================================================
//  Module      : shot_event_detect
//  Description : Tracks a flick shot from trigger to release on paired X/Y
//                samples and reports one event per physical flick: per-axis
//                peaks, combined peak magnitude and length, followed by a
//                cooldown lockout.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                arm               - detector enable (level)
//                x_valid/x_flick   - X sample strobe / magnitude
//                y_valid/y_flick   - Y sample strobe / magnitude
//                shot_valid        - one-cycle pulse, new result on outputs
//                shot_aborted      - one-cycle pulse, burst discarded
//                shot_x_peak/_y_peak/_mag/_len - held result of last shot
//                busy              - high in TRACK, REPORT or COOLDOWN
//  Revision    : 1.0  initial release
// ============================================================================
module shot_event_detect
    import shot_pkg::*;
#(
    parameter logic [MAG_W-1:0] TRIG_TH          = TRIG_TH_DEF,
    parameter logic [MAG_W-1:0] REL_TH           = REL_TH_DEF,
    parameter int               MIN_SAMPLES      = MIN_SAMPLES_DEF,
    parameter int               MAX_SAMPLES      = MAX_SAMPLES_DEF,
    parameter int               COOLDOWN_SAMPLES = COOLDOWN_SAMPLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               x_valid,
    input  logic [FLICK_W-1:0] x_flick,
    input  logic               y_valid,
    input  logic [FLICK_W-1:0] y_flick,
    output logic               shot_valid,
    output logic               shot_aborted,
    output logic [FLICK_W-1:0] shot_x_peak,
    output logic [FLICK_W-1:0] shot_y_peak,
    output logic [MAG_W-1:0]   shot_mag,
    output logic [LEN_W-1:0]   shot_len,
    output logic               busy
);

    localparam logic [LEN_W-1:0] c_min_len = LEN_W'(MIN_SAMPLES);
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_SAMPLES);
    localparam logic [CD_W-1:0]  c_cd_end  = CD_W'(COOLDOWN_SAMPLES);

    logic               w_pair_stb;
    logic [FLICK_W-1:0] w_pair_x;
    logic [FLICK_W-1:0] w_pair_y;

    xy_pair_sync u_pair (
        .clk      (clk),
        .rst      (rst),
        .x_valid  (x_valid),
        .x_flick  (x_flick),
        .y_valid  (y_valid),
        .y_flick  (y_flick),
        .pair_stb (w_pair_stb),
        .pair_x   (w_pair_x),
        .pair_y   (w_pair_y)
    );

    logic [1:0]         r_state;
    logic [FLICK_W-1:0] r_x_pk;
    logic [FLICK_W-1:0] r_y_pk;
    logic [MAG_W-1:0]   r_mag_pk;
    logic [LEN_W-1:0]   r_len;
    logic [CD_W-1:0]    r_cd_cnt;
    logic               r_aborted;
    shot_result_t       r_result;

    logic [MAG_W-1:0]   w_m;
    logic [FLICK_W-1:0] w_x_fold;
    logic [FLICK_W-1:0] w_y_fold;
    logic [MAG_W-1:0]   w_mag_fold;
    logic [LEN_W-1:0]   w_len_inc;
    logic [CD_W-1:0]    w_cd_inc;

    assign w_m        = mag_sum(w_pair_x, w_pair_y);
    assign w_x_fold   = max_flick(r_x_pk, w_pair_x);
    assign w_y_fold   = max_flick(r_y_pk, w_pair_y);
    assign w_mag_fold = (w_m > r_mag_pk) ? w_m : r_mag_pk;
    assign w_len_inc  = r_len + 1'b1;
    assign w_cd_inc   = r_cd_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x_pk    <= '0;
            r_y_pk    <= '0;
            r_mag_pk  <= '0;
            r_len     <= '0;
            r_cd_cnt  <= '0;
            r_aborted <= 1'b0;
            r_result  <= '0;
        end else begin
            r_aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pair_stb && arm && (w_m >= TRIG_TH)) begin
                        r_x_pk   <= w_pair_x;
                        r_y_pk   <= w_pair_y;
                        r_mag_pk <= w_m;
                        r_len    <= LEN_W'(1);
                        // A one-sample maximum reports the trigger sample itself.
                        if (c_max_len == LEN_W'(1)) begin
                            r_state  <= REPORT;
                            r_result <= '{x_peak: w_pair_x, y_peak: w_pair_y,
                                          mag: w_m, len: LEN_W'(1)};
                        end else begin
                            r_state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    // Disarm wins over a same-cycle sample.
                    if (!arm) begin
                        r_state   <= IDLE;
                        r_aborted <= 1'b1;
                    end else if (w_pair_stb) begin
                        if (w_m < REL_TH) begin
                            // Release sample is not part of the shot.
                            if (r_len >= c_min_len) begin
                                r_state  <= REPORT;
                                r_result <= '{x_peak: r_x_pk, y_peak: r_y_pk,
                                              mag: r_mag_pk, len: r_len};
                            end else begin
                                r_state   <= IDLE;
                                r_aborted <= 1'b1;
                            end
                        end else begin
                            r_x_pk   <= w_x_fold;
                            r_y_pk   <= w_y_fold;
                            r_mag_pk <= w_mag_fold;
                            r_len    <= w_len_inc;
                            if (w_len_inc == c_max_len) begin
                                r_state  <= REPORT;
                                r_result <= '{x_peak: w_x_fold, y_peak: w_y_fold,
                                              mag: w_mag_fold, len: w_len_inc};
                            end
                        end
                    end
                end
                REPORT: begin
                    r_state  <= COOLDOWN;
                    r_cd_cnt <= '0;
                end
                COOLDOWN: begin
                    if (w_pair_stb) begin
                        r_cd_cnt <= w_cd_inc;
                        if (w_cd_inc == c_cd_end) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Result registers are written on the edge entering REPORT, so they are
    // already valid during the shot_valid cycle.
    assign shot_valid   = (r_state == REPORT);
    assign shot_aborted = r_aborted;
    assign shot_x_peak  = r_result.x_peak;
    assign shot_y_peak  = r_result.y_peak;
    assign shot_mag     = r_result.mag;
    assign shot_len     = r_result.len;
    assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shot_event_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shot_event_detect
//  Description : Self-checking bench for shot_event_detect: table of pair
//                vectors plus directed multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shot_event_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        x_valid;
    logic [15:0] x_flick;
    logic        y_valid;
    logic [15:0] y_flick;
    logic        shot_valid;
    logic        shot_aborted;
    logic [15:0] shot_x_peak;
    logic [15:0] shot_y_peak;
    logic [16:0] shot_mag;
    logic [7:0]  shot_len;
    logic        busy;

    shot_event_detect dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .x_valid      (x_valid),
        .x_flick      (x_flick),
        .y_valid      (y_valid),
        .y_flick      (y_flick),
        .shot_valid   (shot_valid),
        .shot_aborted (shot_aborted),
        .shot_x_peak  (shot_x_peak),
        .shot_y_peak  (shot_y_peak),
        .shot_mag     (shot_mag),
        .shot_len     (shot_len),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_abort = 0;
    int n_both  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (shot_valid) n_valid++;
            if (shot_aborted) n_abort++;
            if (shot_valid && shot_aborted) n_both++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // x strobe, gap, y strobe (edge N), then one more edge: returns inside
    // cycle N+2, where a release or abort result becomes visible.
    task automatic send_pair(input logic [15:0] x, input logic [15:0] y);
        x_flick = x; x_valid = 1'b1; tick; x_valid = 1'b0;
        tick;
        y_flick = y; y_valid = 1'b1; tick; y_valid = 1'b0;
        tick;
    endtask

    task automatic check_result(input string tag, input logic [15:0] xp, input logic [15:0] yp,
                                input logic [16:0] mg, input logic [7:0] ln);
        check({tag, " x_peak"}, 32'(shot_x_peak), 32'(xp));
        check({tag, " y_peak"}, 32'(shot_y_peak), 32'(yp));
        check({tag, " mag"},    32'(shot_mag),    32'(mg));
        check({tag, " len"},    32'(shot_len),    32'(ln));
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        v;
        logic        a;
        logic        b;
        logic [15:0] xpk;
        logic [15:0] ypk;
        logic [16:0] mag;
        logic [7:0]  len;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // Normal shot, cooldown lockout, then a short burst
        vecs[0]  = '{16'd10,  16'd10, 1'b0, 1'b0, 1'b0, 16'd0,   16'd0,  17'd0,   8'd0};
        vecs[1]  = '{16'd150, 16'd60, 1'b0, 1'b0, 1'b1, 16'd0,   16'd0,  17'd0,   8'd0};
        vecs[2]  = '{16'd300, 16'd90, 1'b0, 1'b0, 1'b1, 16'd0,   16'd0,  17'd0,   8'd0};
        vecs[3]  = '{16'd220, 16'd40, 1'b0, 1'b0, 1'b1, 16'd0,   16'd0,  17'd0,   8'd0};
        vecs[4]  = '{16'd30,  16'd20, 1'b1, 1'b0, 1'b1, 16'd300, 16'd90, 17'd390, 8'd3};
        for (int i = 5; i <= 11; i++)
            vecs[i] = '{16'd250, 16'd0, 1'b0, 1'b0, 1'b1, 16'd300, 16'd90, 17'd390, 8'd3};
        vecs[12] = '{16'd250, 16'd0,  1'b0, 1'b0, 1'b0, 16'd300, 16'd90, 17'd390, 8'd3};
        vecs[13] = '{16'd250, 16'd0,  1'b0, 1'b0, 1'b1, 16'd300, 16'd90, 17'd390, 8'd3};
        vecs[14] = '{16'd40,  16'd0,  1'b0, 1'b1, 1'b0, 16'd300, 16'd90, 17'd390, 8'd3};

        rst = 1'b1; arm = 1'b0;
        x_valid = 1'b0; y_valid = 1'b0; x_flick = '0; y_flick = '0;
        tick; tick;
        check("reset valid", 32'(shot_valid), 0);
        check("reset abort", 32'(shot_aborted), 0);
        check("reset busy", 32'(busy), 0);
        check_result("reset", 16'd0, 16'd0, 17'd0, 8'd0);
        rst = 1'b0; arm = 1'b1;
        tick;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 15; i++) begin
            send_pair(vecs[i].x, vecs[i].y);
            check($sformatf("vec%0d valid", i), 32'(shot_valid), 32'(vecs[i].v));
            check($sformatf("vec%0d abort", i), 32'(shot_aborted), 32'(vecs[i].a));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].b));
            check_result($sformatf("vec%0d", i), vecs[i].xpk, vecs[i].ypk, vecs[i].mag, vecs[i].len);
        end

        // ---------------- timeout ----------------
        for (int i = 1; i <= 73; i++) begin
            send_pair(16'd120, 16'd120);
            check($sformatf("timeout%0d valid", i), 32'(shot_valid), (i == 64) ? 1 : 0);
            check($sformatf("timeout%0d busy", i), 32'(busy), (i == 72) ? 0 : 1);
            if (i == 64) check_result("timeout", 16'd120, 16'd120, 17'd240, 8'd64);
        end

        // ---------------- disarm mid-TRACK, same cycle as pair_stb ----------------
        x_flick = 16'd300; x_valid = 1'b1; tick; x_valid = 1'b0;
        tick;
        y_flick = 16'd300; y_valid = 1'b1; tick; y_valid = 1'b0;
        arm = 1'b0;
        tick;
        check("disarm abort", 32'(shot_aborted), 1);
        check("disarm valid", 32'(shot_valid), 0);
        check("disarm busy", 32'(busy), 0);
        check_result("disarm", 16'd120, 16'd120, 17'd240, 8'd64);
        tick;
        check("disarm abort pulse width", 32'(shot_aborted), 0);
        send_pair(16'd300, 16'd300);
        check("disarmed idle busy", 32'(busy), 0);
        arm = 1'b1;

        // ---------------- pairing corner cases ----------------
        // simultaneous x/y -> one trigger pair
        x_flick = 16'd100; y_flick = 16'd100; x_valid = 1'b1; y_valid = 1'b1;
        tick; x_valid = 1'b0; y_valid = 1'b0;
        tick; tick;
        check("simul busy", 32'(busy), 1);
        // double x: second x (200) must be used, first (5) would release
        x_flick = 16'd5; x_valid = 1'b1; tick; x_valid = 1'b0; tick;
        x_flick = 16'd200; x_valid = 1'b1; tick; x_valid = 1'b0; tick;
        y_flick = 16'd50; y_valid = 1'b1; tick; y_valid = 1'b0; tick; tick;
        check("double x busy", 32'(busy), 1);
        check("double x abort", 32'(shot_aborted), 0);
        // lone y: must not form a pair
        y_flick = 16'd0; y_valid = 1'b1; tick; y_valid = 1'b0; tick; tick;
        check("lone y busy", 32'(busy), 1);
        send_pair(16'd50, 16'd60);
        check("pairing third valid", 32'(shot_valid), 0);
        send_pair(16'd10, 16'd10);
        check("pairing report valid", 32'(shot_valid), 1);
        check_result("pairing", 16'd200, 16'd100, 17'd250, 8'd3);

        for (int i = 0; i < 8; i++) send_pair(16'd0, 16'd0);
        check("post cooldown busy", 32'(busy), 0);

        // ---------------- reset mid-TRACK ----------------
        send_pair(16'd250, 16'd0);
        send_pair(16'd250, 16'd0);
        check("pre-reset busy", 32'(busy), 1);
        x_flick = 16'd0; x_valid = 1'b1; tick; x_valid = 1'b0; tick;
        y_flick = 16'd0; y_valid = 1'b1; tick; y_valid = 1'b0;
        rst = 1'b1;
        tick;
        check("rst valid", 32'(shot_valid), 0);
        check("rst abort", 32'(shot_aborted), 0);
        check("rst busy", 32'(busy), 0);
        check_result("rst", 16'd0, 16'd0, 17'd0, 8'd0);
        rst = 1'b0;
        tick;
        check("post rst abort", 32'(shot_aborted), 0);
        check("post rst busy", 32'(busy), 0);
        tick;

        // ---------------- pulse totals ----------------
        check("total shot_valid pulses", 32'(n_valid), 3);
        check("total shot_aborted pulses", 32'(n_abort), 2);
        check("valid and aborted together", 32'(n_both), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
